// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the execute stage and the HI/LO multiply/divide unit
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output start, op, a, b, abort, input busy, done, hi, lo);
   modport slave (input start, op, a, b, abort, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 HI/LO multiply/divide unit with MTHI/MTLO and flush abort
module muldiv_unit #(
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc, acc_step, prod;
   logic [WIDTH-1:0]   dsr, a_mag, b_mag, quo, rem, hi_r, lo_r, hi_res, lo_res;
   logic [WIDTH:0]     sum, diff;
   logic               is_div, neg_q, neg_r, div0, sgn, idle_go, issue, done_r;
   always_comb begin
      idle_go  = state == IDLE && bus.start && !bus.abort;
      issue    = idle_go && !bus.op[2];
      sgn      = !bus.op[0];
      a_mag    = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag    = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      state_nx = bus.abort ? IDLE :
                 state == IDLE ? (issue ? RUN : IDLE) :
                 state == RUN ? (cnt == '0 ? FIX : RUN) : IDLE;
   end
   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dsr} : '0);
      diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dsr};
      acc_step = !is_div ? {sum, acc[WIDTH-1:1]} :
                 diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                 {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      quo      = acc[WIDTH-1:0];
      rem      = acc[2*WIDTH-1:WIDTH];
      prod     = neg_q ? -acc : acc;
      hi_res   = is_div ? (neg_r ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
      lo_res   = is_div ? (div0 ? '1 : neg_q ? -quo : quo) : prod[WIDTH-1:0];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         dsr    <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
      end else begin
         state  <= state_nx;
         done_r <= state == FIX && !bus.abort;
         if (issue) begin
            cnt    <= CNT_W'(WIDTH - 1);
            acc    <= {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
            dsr    <= bus.op[1] ? b_mag : a_mag;
            is_div <= bus.op[1];
            neg_q  <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= sgn && bus.a[WIDTH-1];
            div0   <= bus.b == '0;
         end else if (state == RUN) begin
            acc <= acc_step;
            cnt <= cnt - CNT_W'(1);
         end
         if (state == FIX && !bus.abort) begin
            hi_r <= hi_res;
            lo_r <= lo_res;
         end
         if (idle_go && bus.op == 3'd4) hi_r <= bus.a;
         if (idle_go && bus.op == 3'd5) lo_r <= bus.a;
      end
   end
   assign bus.busy = state != IDLE;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit at WIDTH=32 and WIDTH=8
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0, failures = 0, dn32 = 0, dn8 = 0;
   typedef struct packed {
      logic [5:0]  w;
      logic [2:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;
   localparam vec_t VECS [10] = '{
      '{6'd32, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{6'd32, 3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
      '{6'd32, 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{6'd32, 3'd3, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF},
      '{6'd32, 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{6'd8,  3'd1, 32'hFF,       32'hFF,       32'hFE,       32'h01},
      '{6'd8,  3'd0, 32'hFD,       32'h07,       32'hFF,       32'hEB},
      '{6'd8,  3'd2, 32'hF9,       32'h02,       32'hFF,       32'hFD},
      '{6'd8,  3'd3, 32'd100,      32'h00,       32'd100,      32'hFF},
      '{6'd8,  3'd2, 32'h80,       32'hFF,       32'h00,       32'h80}
   };
   muldiv_if #(.WIDTH(32)) b32();
   muldiv_if #(.WIDTH(8))  b8();
   muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
   muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (b32.done) dn32++;
      if (b8.done) dn8++;
   end
   // Reference: plain integer arithmetic on w-bit values held in 64-bit variables
   function automatic void model(input int w, input logic [2:0] op, input logic [31:0] a, b,
                                 output logic [31:0] hi, lo);
      logic [63:0] mask, ua, ub, hv, lv, p;
      longint      sa, sb;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, a} & mask;
      ub   = {32'd0, b} & mask;
      sa   = ua[w-1] ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
      sb   = ub[w-1] ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
      hv   = '0;
      lv   = '0;
      if (!op[1]) begin
         if (op[0]) p = ua * ub;
         else p = sa * sb;
         hv = p >> w;
         lv = p;
      end else if (ub == 0) begin
         hv = ua;
         lv = mask;
      end else if (op[0]) begin
         hv = ua % ub;
         lv = ua / ub;
      end else begin
         hv = sa % sb;
         lv = sa / sb;
      end
      hi = 32'(hv & mask);
      lo = 32'(lv & mask);
   endfunction
   task automatic drive(input int w, input logic s, input logic [2:0] op, input logic [31:0] a, b,
                        input logic ab);
      if (w == 32) begin
         b32.start = s; b32.op = op; b32.a = a; b32.b = b; b32.abort = ab;
      end else begin
         b8.start = s; b8.op = op; b8.a = a[7:0]; b8.b = b[7:0]; b8.abort = ab;
      end
   endtask
   function automatic logic [31:0] get_hi(input int w);
      return w == 32 ? b32.hi : {24'd0, b8.hi};
   endfunction
   function automatic logic [31:0] get_lo(input int w);
      return w == 32 ? b32.lo : {24'd0, b8.lo};
   endfunction
   function automatic logic get_busy(input int w);
      return w == 32 ? b32.busy : b8.busy;
   endfunction
   function automatic logic get_done(input int w);
      return w == 32 ? b32.done : b8.done;
   endfunction
   // Issues one op and waits (bounded) for done; lat is the edge count after issue, 0 on timeout
   task automatic do_op(input int w, input logic [2:0] op, input logic [31:0] a, b,
                        output int lat, output int bc, output logic [31:0] hi, lo);
      @(negedge clk);
      drive(w, 1'b1, op, a, b, 1'b0);
      @(negedge clk);
      drive(w, 1'b0, op, a, b, 1'b0);
      lat = 0;
      bc  = int'(get_busy(w));
      for (int k = 1; k <= 3 * w && lat == 0; k++) begin
         @(negedge clk);
         bc += int'(get_busy(w));
         if (get_done(w)) lat = k;
      end
      hi = get_hi(w);
      lo = get_lo(w);
   endtask
   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks += 5;
      if (b32.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", b32.hi); end
      if (b32.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", b32.lo); end
      if (b32.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", b32.busy); end
      if (b32.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", b32.done); end
      if (b8.hi !== 8'd0) begin failures++; $display("FAIL reset_hi8 got=%h exp=0", b8.hi); end
      @(negedge clk);
      rst = 1'b1;
   endtask
   task automatic test_vectors;
      int lat, bc;
      logic [31:0] hi, lo;
      for (int i = 0; i < 10; i++) begin
         do_op(int'(VECS[i].w), VECS[i].op, VECS[i].a, VECS[i].b, lat, bc, hi, lo);
         checks += 4;
         if (hi !== VECS[i].hi) begin failures++; $display("FAIL vec%0d_hi got=%h exp=%h", i, hi, VECS[i].hi); end
         if (lo !== VECS[i].lo) begin failures++; $display("FAIL vec%0d_lo got=%h exp=%h", i, lo, VECS[i].lo); end
         if (lat != int'(VECS[i].w) + 1) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, VECS[i].w + 1); end
         if (bc != int'(VECS[i].w) + 1) begin failures++; $display("FAIL vec%0d_busy_cycles got=%0d exp=%0d", i, bc, VECS[i].w + 1); end
      end
   endtask
   task automatic test_random;
      int w, lat, bc, pick;
      logic [2:0] op;
      logic [31:0] a, b, hi, lo, ehi, elo;
      for (int i = 0; i < 60; i++) begin
         w    = ($urandom_range(0, 1) == 1) ? 32 : 8;
         op   = 3'($urandom_range(0, 3));
         a    = $urandom;
         b    = $urandom;
         pick = int'($urandom_range(0, 7));
         if (pick == 0) b = '0;
         if (pick == 1) begin
            a = (w == 32) ? 32'h80000000 : 32'h80;
            b = '1;
         end
         model(w, op, a, b, ehi, elo);
         do_op(w, op, a, b, lat, bc, hi, lo);
         checks += 3;
         if (hi !== ehi) begin failures++; $display("FAIL rand%0d_hi w=%0d op=%0d a=%h b=%h got=%h exp=%h", i, w, op, a, b, hi, ehi); end
         if (lo !== elo) begin failures++; $display("FAIL rand%0d_lo w=%0d op=%0d a=%h b=%h got=%h exp=%h", i, w, op, a, b, lo, elo); end
         if (lat != w + 1) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, w + 1); end
      end
   endtask
   task automatic test_reset_mid_run;
      int saved;
      @(negedge clk);
      drive(32, 1'b1, 3'd4, 32'hDEADBEEF, 32'd0, 1'b0);
      @(negedge clk);
      drive(32, 1'b1, 3'd0, 32'd12345, 32'd678, 1'b0);
      checks++;
      if (b32.hi !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_reset_mthi got=%h exp=deadbeef", b32.hi); end
      @(negedge clk);
      drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      saved = dn32;
      #1;
      checks += 3;
      if (b32.hi !== 32'd0) begin failures++; $display("FAIL midrst_hi got=%h exp=0", b32.hi); end
      if (b32.lo !== 32'd0) begin failures++; $display("FAIL midrst_lo got=%h exp=0", b32.lo); end
      if (b32.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", b32.busy); end
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      checks += 2;
      if (dn32 != saved) begin failures++; $display("FAIL midrst_no_done got=%0d exp=%0d", dn32, saved); end
      if (b32.busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b exp=0", b32.busy); end
   endtask
   task automatic test_abort;
      int saved, lat, bc;
      logic [31:0] hi, lo;
      @(negedge clk);
      drive(32, 1'b1, 3'd4, 32'h1234, 32'd0, 1'b0);
      @(negedge clk);
      drive(32, 1'b1, 3'd5, 32'h5678, 32'd0, 1'b0);
      @(negedge clk);
      drive(32, 1'b1, 3'd3, 32'd1000, 32'd7, 1'b0);
      @(negedge clk);
      drive(32, 1'b0, 3'd3, 32'd1000, 32'd7, 1'b0);
      repeat (5) @(negedge clk);
      saved = dn32;
      drive(32, 1'b0, 3'd3, 32'd1000, 32'd7, 1'b1);
      @(negedge clk);
      drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      checks += 3;
      if (b32.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", b32.busy); end
      if (b32.hi !== 32'h1234) begin failures++; $display("FAIL abort_hi got=%h exp=1234", b32.hi); end
      if (b32.lo !== 32'h5678) begin failures++; $display("FAIL abort_lo got=%h exp=5678", b32.lo); end
      repeat (2) @(negedge clk);
      checks++;
      if (dn32 != saved) begin failures++; $display("FAIL abort_no_done got=%0d exp=%0d", dn32, saved); end
      do_op(32, 3'd3, 32'd1000, 32'd7, lat, bc, hi, lo);
      @(negedge clk);
      checks += 4;
      if (hi !== 32'd6) begin failures++; $display("FAIL post_abort_hi got=%h exp=6", hi); end
      if (lo !== 32'd142) begin failures++; $display("FAIL post_abort_lo got=%h exp=8e", lo); end
      if (lat != 33) begin failures++; $display("FAIL post_abort_latency got=%0d exp=33", lat); end
      if (dn32 != saved + 1) begin failures++; $display("FAIL post_abort_done_count got=%0d exp=%0d", dn32, saved + 1); end
      drive(32, 1'b1, 3'd1, 32'd9, 32'd9, 1'b1);
      @(negedge clk);
      drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      checks += 2;
      if (b32.busy !== 1'b0) begin failures++; $display("FAIL abort_start_busy got=%b exp=0", b32.busy); end
      if (b32.lo !== 32'd142) begin failures++; $display("FAIL abort_start_lo got=%h exp=8e", b32.lo); end
   endtask
   task automatic test_mthi_mtlo;
      @(negedge clk);
      drive(32, 1'b1, 3'd4, 32'hA5A5A5A5, 32'd0, 1'b0);
      drive(8, 1'b1, 3'd5, 32'hC3, 32'd0, 1'b0);
      @(negedge clk);
      checks += 3;
      if (b32.busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", b32.busy); end
      if (b32.hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL mthi_hi got=%h exp=a5a5a5a5", b32.hi); end
      if (b8.lo !== 8'hC3) begin failures++; $display("FAIL mtlo8_lo got=%h exp=c3", b8.lo); end
      drive(32, 1'b1, 3'd5, 32'h5A5A5A5A, 32'd0, 1'b0);
      drive(8, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checks += 3;
      if (b32.busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b exp=0", b32.busy); end
      if (b32.lo !== 32'h5A5A5A5A) begin failures++; $display("FAIL mtlo_lo got=%h exp=5a5a5a5a", b32.lo); end
      if (b32.hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=a5a5a5a5", b32.hi); end
      drive(32, 1'b1, 3'd6, 32'h11111111, 32'd0, 1'b0);
      @(negedge clk);
      drive(32, 1'b1, 3'd7, 32'h22222222, 32'd0, 1'b0);
      @(negedge clk);
      drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      checks += 3;
      if (b32.busy !== 1'b0) begin failures++; $display("FAIL noop_busy got=%b exp=0", b32.busy); end
      if (b32.hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL noop_hi got=%h exp=a5a5a5a5", b32.hi); end
      if (b32.lo !== 32'h5A5A5A5A) begin failures++; $display("FAIL noop_lo got=%h exp=5a5a5a5a", b32.lo); end
   endtask
   task automatic test_back_to_back;
      int lat, saved;
      logic [31:0] ehi, elo;
      model(32, 3'd1, 32'h00010000, 32'h30, ehi, elo);
      saved = dn32;
      @(negedge clk);
      drive(32, 1'b1, 3'd1, 32'h00010000, 32'h30, 1'b0);
      @(negedge clk);
      drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      lat = 0;
      for (int k = 1; k <= 100 && lat == 0; k++) begin
         @(negedge clk);
         if (b32.done) lat = k;
         if (k == 3) drive(32, 1'b1, 3'd0, 32'hFFFFFFFF, 32'd5, 1'b0);
         if (k == 4) drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      end
      checks += 3;
      if (lat != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
      if (b32.hi !== ehi) begin failures++; $display("FAIL b2b_hi got=%h exp=%h", b32.hi, ehi); end
      if (b32.lo !== elo) begin failures++; $display("FAIL b2b_lo got=%h exp=%h", b32.lo, elo); end
      repeat (3) @(negedge clk);
      checks += 2;
      if (b32.busy !== 1'b0) begin failures++; $display("FAIL b2b_no_second_op got=%b exp=0", b32.busy); end
      if (dn32 != saved + 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=%0d", dn32, saved + 1); end
   endtask
   initial begin
      drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      drive(8, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      test_reset;
      test_vectors;
      test_mthi_mtlo;
      test_abort;
      test_back_to_back;
      test_random;
      test_reset_mid_run;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
